// File: rtl/bf16_pkg.sv
// Shared types and constants for the bfloat16 multiplier.
package bf16_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] frac;
    } bf16_t;

    localparam int          BIAS    = 127;
    localparam logic [15:0] QNAN    = 16'h7FC0;
    localparam int          EXP_MAX = 255;

    typedef enum logic [1:0] {
        START = 2'd0,
        LOAD  = 2'd1,
        MULT  = 2'd2,
        NORM  = 2'd3
    } state_t;

    function automatic logic is_nan(input bf16_t v);
        return (v.exp == 8'hFF) && (v.frac != 7'h0);
    endfunction

    function automatic logic is_inf(input bf16_t v);
        return (v.exp == 8'hFF) && (v.frac == 7'h0);
    endfunction

    // Subnormals are flushed, so any zero exponent counts as zero.
    function automatic logic is_zero(input bf16_t v);
        return v.exp == 8'h00;
    endfunction

endpackage

// File: rtl/bf16_norm_round.sv
// Normalises a 16-bit mantissa product, rounds to nearest-even and applies
// special-case overrides to produce the packed bfloat16 result.
module bf16_norm_round
    import bf16_pkg::*;
(
    input  logic              sign,
    input  logic signed [9:0] exp_in,
    input  logic [15:0]       mant,
    input  logic              nan_in,
    input  logic              inf_in,
    input  logic              zero_in,
    output logic [15:0]       result
);

    logic signed [9:0] exp_n;
    logic signed [9:0] exp_r;
    logic [6:0]        kept;
    logic              guard_bit;
    logic              round_bit;
    logic              sticky_bit;
    logic              round_up;
    logic [7:0]        frac_r;

    always_comb begin
        exp_n      = exp_in;
        kept       = mant[13:7];
        guard_bit  = mant[6];
        round_bit  = mant[5];
        sticky_bit = |mant[4:0];
        if (mant[15]) begin
            exp_n      = exp_in + 10'sd1;
            kept       = mant[14:8];
            guard_bit  = mant[7];
            round_bit  = mant[6];
            sticky_bit = |mant[5:0];
        end

        round_up = guard_bit & (round_bit | sticky_bit | kept[0]);
        frac_r   = {1'b0, kept} + {7'h0, round_up};
        // A carry out leaves frac_r[6:0] all zero, i.e. mantissa 1.0 at exp+1.
        exp_r    = frac_r[7] ? exp_n + 10'sd1 : exp_n;

        if (nan_in)
            result = QNAN;
        else if (inf_in)
            result = {sign, 8'hFF, 7'h0};
        else if (zero_in)
            result = {sign, 15'h0};
        else if (exp_r >= 10'(EXP_MAX))
            result = {sign, 8'hFF, 7'h0};
        else if (exp_r <= 10'sd0)
            result = {sign, 15'h0};
        else
            result = {sign, exp_r[7:0], frac_r[6:0]};
    end

endmodule

// File: rtl/bfloat16_multiplier.sv
// Free-running bfloat16 multiplier: captures operands while ready is high,
// shift-add multiplies the mantissas over 8 cycles, then normalises and rounds.
//
// state | meaning
// START | post-reset, raise ready on the next edge
// LOAD  | ready high, operands captured on the closing edge
// MULT  | one multiplier bit accumulated per cycle (8 cycles)
// NORM  | register rounded product, raise ready
module bfloat16_multiplier
    import bf16_pkg::*;
(
    input  logic        clock,
    input  logic        nreset,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] product,
    output logic        ready
);

    state_t      state_q, state_d;
    bf16_t       a_q, a_d;
    bf16_t       b_q, b_d;
    logic [2:0]  step_q, step_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] product_q, product_d;
    logic        ready_q, ready_d;

    logic [15:0]       ma_ext;
    logic [7:0]        mb;
    logic signed [9:0] exp_sum;
    logic              nan_flag;
    logic              inf_flag;
    logic              zero_flag;
    logic [15:0]       norm_result;

    assign ma_ext  = {8'h00, 1'b1, a_q.frac};
    assign mb      = {1'b1, b_q.frac};
    assign exp_sum = signed'({2'b00, a_q.exp}) + signed'({2'b00, b_q.exp}) - 10'(BIAS);

    assign nan_flag  = is_nan(a_q) || is_nan(b_q) ||
                       (is_inf(a_q) && is_zero(b_q)) || (is_inf(b_q) && is_zero(a_q));
    assign inf_flag  = is_inf(a_q) || is_inf(b_q);
    assign zero_flag = is_zero(a_q) || is_zero(b_q);

    bf16_norm_round u_norm_round (
        .sign    (a_q.sign ^ b_q.sign),
        .exp_in  (exp_sum),
        .mant    (acc_q),
        .nan_in  (nan_flag),
        .inf_in  (inf_flag),
        .zero_in (zero_flag),
        .result  (norm_result)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        step_d    = step_q;
        acc_d     = acc_q;
        product_d = product_q;
        ready_d   = ready_q;
        case (state_q)
            START: begin
                ready_d = 1'b1;
                state_d = LOAD;
            end
            LOAD: begin
                a_d     = a;
                b_d     = b;
                acc_d   = 16'h0;
                step_d  = 3'd0;
                ready_d = 1'b0;
                state_d = MULT;
            end
            MULT: begin
                if (mb[step_q])
                    acc_d = acc_q + (ma_ext << step_q);
                step_d = step_q + 3'd1;
                if (step_q == 3'd7)
                    state_d = NORM;
            end
            NORM: begin
                product_d = norm_result;
                ready_d   = 1'b1;
                state_d   = LOAD;
            end
            default: state_d = START;
        endcase
    end

    always_ff @(posedge clock or posedge nreset) begin
        if (nreset) begin
            state_q   <= START;
            a_q       <= '0;
            b_q       <= '0;
            step_q    <= 3'd0;
            acc_q     <= 16'h0;
            product_q <= 16'h0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            step_q    <= step_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            ready_q   <= ready_d;
        end
    end

    assign product = product_q;
    assign ready   = ready_q;

endmodule

// File: tb/tb_bfloat16_multiplier.sv
// Scoreboard bench for bfloat16_multiplier: a driver pushes expected results
// at each operand capture and a monitor pops them on every ready pulse.
module tb_bfloat16_multiplier;

    logic        clock;
    logic        nreset;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] product;
    logic        ready;

    typedef struct packed {
        logic [15:0] expv;
        logic [7:0]  id;
    } sb_t;

    sb_t sb[$];
    int  n_vec = 0;
    int  n_err = 0;
    bit  mon_en = 0;

    bfloat16_multiplier dut (
        .clock   (clock),
        .nreset  (nreset),
        .a       (a),
        .b       (b),
        .product (product),
        .ready   (ready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Monitor: result check on each ready pulse, pulse width/period, product hold.
    logic        ready_prev = 1'b0;
    logic [15:0] prev_product = 16'h0;
    bit          rise_seen = 0;
    int          since = 0;

    always @(negedge clock) begin
        if (!mon_en) begin
            ready_prev   = 1'b0;
            rise_seen    = 0;
            since        = 0;
            prev_product = product;
        end else begin
            since++;
            if (ready) begin
                if (ready_prev) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL ready_width: got ready high 2+ cycles, required 1");
                end else begin
                    if (rise_seen) begin
                        n_vec++;
                        if (since != 10) begin
                            n_err++;
                            $display("FAIL ready_period: got %0d cycles, required 10", since);
                        end
                    end
                    rise_seen = 1;
                    since     = 0;
                    if (sb.size() > 0) begin
                        sb_t e;
                        e = sb.pop_front();
                        n_vec++;
                        if (product !== e.expv) begin
                            n_err++;
                            $display("FAIL product vec %0d: got %h, required %h", e.id, product, e.expv);
                        end
                    end
                end
            end else begin
                n_vec++;
                if (product !== prev_product) begin
                    n_err++;
                    $display("FAIL product_hold: got %h, required %h", product, prev_product);
                end
            end
            ready_prev   = ready;
            prev_product = product;
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic apply(input logic [15:0] va, input logic [15:0] vb,
                         input logic [15:0] ev, input logic [7:0] id);
        bit got;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clock);
            if (ready) got = 1;
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout vec %0d: got ready 0, required 1", id);
        end else begin
            a = va;
            b = vb;
            @(posedge clock);
            sb.push_back({ev, id});
        end
    endtask

    localparam int NV = 14;
    logic [15:0] va_t [NV] = '{16'h3F80, 16'h3FC0, 16'hC000, 16'h3F81, 16'h3F81, 16'h3F83, 16'h3F92,
                               16'h7F00, 16'h7F80, 16'h8000, 16'h0080, 16'h7FC1, 16'h7F80, 16'h3FFF};
    logic [15:0] vb_t [NV] = '{16'h4040, 16'h3FC0, 16'h4040, 16'h3F81, 16'h4040, 16'h4040, 16'h3FE0,
                               16'h4000, 16'h0000, 16'h4040, 16'h0080, 16'h3F80, 16'hC000, 16'h3FFF};
    logic [15:0] ve_t [NV] = '{16'h4040, 16'h4010, 16'hC0C0, 16'h3F82, 16'h4042, 16'h4044, 16'h4000,
                               16'h7F80, 16'h7FC0, 16'h8000, 16'h0000, 16'h7FC0, 16'hFF80, 16'h407E};

    initial begin
        nreset = 1'b1;
        a      = 16'h0;
        b      = 16'h0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        nreset = 1'b0;
        #1;
        chk("reset_product", product, 16'h0000);
        chk("reset_ready", {15'h0, ready}, 16'h0000);
        mon_en = 1;
        @(posedge clock);
        #1;
        chk("first_ready", {15'h0, ready}, 16'h0001);

        for (int i = 0; i < NV; i++)
            apply(va_t[i], vb_t[i], ve_t[i], 8'(i));

        // Held operands: identical results every 10 cycles.
        for (int i = 0; i < 3; i++)
            apply(16'h4040, 16'h3FC0, 16'h4090, 8'(100 + i));

        // Abort mid-computation.
        apply(16'h3F80, 16'h4040, 16'h4040, 8'd200);
        repeat (3) @(posedge clock);
        mon_en = 0;
        #2;
        nreset = 1'b1;
        #1;
        chk("abort_product", product, 16'h0000);
        chk("abort_ready", {15'h0, ready}, 16'h0000);
        sb.delete();
        repeat (2) @(posedge clock);
        @(negedge clock);
        nreset = 1'b0;
        #1;
        chk("release_ready", {15'h0, ready}, 16'h0000);
        mon_en = 1;
        @(posedge clock);
        #1;
        chk("release_first_ready", {15'h0, ready}, 16'h0001);
        apply(16'hC000, 16'hC000, 16'h4080, 8'd201);

        for (int i = 0; i < 40 && sb.size() > 0; i++)
            @(negedge clock);
        if (sb.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d pending results, required 0", sb.size());
        end
        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bfloat16_multiplier.md
# bfloat16_multiplier

Multi-cycle sequential multiplier for two bfloat16 operands (1 sign, 8 exponent bits with bias 127, 7 fraction bits). It runs continuously: each time `ready` is high it captures `a`/`b`, computes the product with an 8-step shift-add mantissa multiplier, then normalises and rounds, registers `product`, and raises `ready` again. It serves as a low-area FP multiply unit for datapaths that can tolerate a fixed 10-cycle throughput and have no start/valid signalling.

## Interface
- No parameters; format fixed to bfloat16.
- `clock`  in  1  rising-edge clock.
- `nreset`  in  1  reset, asynchronous, active-high; name kept as in codebase, polarity fixed high.
- `a`  in  16  operand A, bfloat16, sampled on the edge that ends a `ready` cycle.
- `b`  in  16  operand B, same sampling as `a`.
- `product`  out  16  registered bfloat16 result, held until the next result.
- `ready`  out  1  registered; high for exactly one cycle when `product` updates; that cycle is also the operand-capture window.

## Operation
- States:
  - START: reset state; next edge goes to LOAD with `ready`<=1.
  - LOAD: `ready`=1; next edge captures `a`/`b`, sets `ready`<=0, goes to MULT.
  - MULT: 8 cycles, one multiplicand bit per cycle.
  - NORM: one cycle; writes `product`, sets `ready`<=1, goes to LOAD.
- There is no idle stall: operands are captured every LOAD cycle whether they changed or not.
- Sign: `sa` XOR `sb`.
- Mantissas: 8 bits including the hidden 1. Product is 16 bits unsigned, in range [1,4).
- Exponent: 10-bit signed intermediate, `ea + eb - 127`; add 1 when product bit 15 is set, with the mantissa shifted right 1.
- Rounding: round-to-nearest, ties-to-even, using guard, round and sticky bits from the discarded product bits. If rounding carries out of the mantissa, renormalise and increment the exponent.
- Special cases, in priority order:
  - Any NaN input (exp=255, frac≠0), or inf×0: output 0x7FC0.
  - Either input inf: output signed inf, `{s,8'hFF,7'h0}`.
  - Either input zero or subnormal (exp=0; denormals are flushed): output signed zero.
  - Final exponent ≥255: output signed inf.
  - Final exponent ≤0: output signed zero (flush to zero, no denormal output).

## Timing
- Reset values: `product`=0x0000, `ready`=0, state=START; all internal registers cleared.
- Reset is asynchronous. Asserting it mid-computation aborts that computation; `product` returns to 0.
- After reset release: `ready` rises on the 1st edge, operands are captured on the 2nd edge.
- With capture at edge E0:
  - MULT steps occur on E1..E8.
  - E9 updates `product` and raises `ready`.
  - E10 lowers `ready` and captures the next operands.
- Throughput: one result every 10 cycles. `ready` is a 1-cycle pulse at period 10.
- `product` is stable from E9 until E19. It is valid when sampled at E10, so a consumer can wait for `ready` to rise, then sample on the following edge.
- Operand changes outside the capture edge have no effect.

## Structure
- Package `bf16_pkg`:
  - typedef `bf16_t` struct (sign, exp[7:0], frac[6:0]).
  - constants: BIAS=127, QNAN=16'h7FC0, EXP_MAX=255.
  - state enum: START, LOAD, MULT, NORM.
- Top module holds the FSM, operand registers, the 3-bit step counter and the shift-add accumulator.
- One combinational sub-module, `bf16_norm_round`: takes sign, 10-bit exponent, 16-bit mantissa product and special-case flags, and returns the packed 16-bit result.

## Test plan
- 1.0 (0x3F80) × 3.0 (0x4040) captured at first `ready` → next `ready` pulse, `product`=0x4040 (3.0), still 0x4040 one edge later.
- 1.5 (0x3FC0) × 1.5 → 0x4010 (2.25); −2.0 (0xC000) × 3.0 → 0xC0C0 (−6.0).
- Rounding: 0x3F81 × 0x3F81 → 0x3F82. Also check a tie case, which must round to even.
- Specials:
  - 0x7F00 × 0x4000 → 0x7F80 (overflow to inf).
  - 0x7F80 × 0x0000 → 0x7FC0 (NaN).
  - 0x8000 × 0x4040 → 0x8000 (signed zero).
  - 0x0080 × 0x0080 → 0x0000 (underflow to zero).
- Cadence: hold operands constant. `ready` must pulse for 1 cycle every 10 cycles, with `product` changing only on pulse-rising edges.
- Assert `nreset` during MULT → `product`=0 and `ready`=0 immediately. After release, `ready` rises on the 1st edge and a fresh capture and result follow.
